ballot_unit: RTL and testbench
==============================

# ballot_unit

Ballot-side front end of the voting machine. It arms one vote per presiding-officer `arm` pulse and debounces four candidate buttons. It then transmits exactly one 2-bit candidate code to the vote-counting control unit over a valid/ack handshake. It sits between the physical button panel and the counter block whose `s` input it drives.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a single button must be held stable before the vote is accepted (≥1).
- `TIMEOUT_CYCLES`, 1000, cycles an armed ballot waits for a valid press before it disarms (≥1; used only with the timeout feature).
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `arm` input 1: presiding-officer enable, level-sampled; acted on only in IDLE.
- `btn` input 4: candidate buttons, `btn[k]` = candidate k, active-high.
- `vote_ack` input 1: counter acknowledges the vote currently on `vote_sel`.
- `vote_valid` output 1: vote offered to the counter.
- `vote_sel` output 2: candidate code, 00..11, equal to the counter's `s` encoding.
- `ready` output 1: ballot armed and waiting for a press (voter lamp).
- `busy` output 1: high in every state except IDLE.
- `votes_cast` output 16: number of acknowledged votes since reset, saturating.
- `timeout` output 1: one-cycle pulse when an armed ballot expires.

## Operation
- States: IDLE, ARMED, SEND, DONE.
- IDLE → ARMED when `arm`=1 and `btn`=4'b0000.
  - A press already held at arm time blocks arming until all buttons are released.
- ARMED, `btn` one-hot:
  - Compare against the candidate latched last cycle.
  - Same one-hot value: increment the debounce counter.
  - Different value: reload the counter to 1 and latch the new candidate.
- ARMED, `btn` zero or multi-hot: clear the debounce counter. Multi-hot presses never produce a vote.
- ARMED → SEND when the debounce counter reaches `DEBOUNCE_CYCLES`. The one-hot code is encoded into `vote_sel` in the same transition.
- SEND: hold `vote_valid`=1 with `vote_sel` stable. When `vote_ack`=1 is sampled, go to DONE and increment `votes_cast` (saturate at 16'hFFFF).
- DONE: one cycle, then IDLE. Button activity in DONE is ignored.
- `arm` in any state other than IDLE is ignored. It does not queue a second vote.
- `vote_ack` outside SEND is ignored.
- `btn` changes in SEND do not alter `vote_sel`.

## Timing
- Reset values:
  - State IDLE.
  - `vote_valid`=0, `vote_sel`=2'b00, `ready`=0, `busy`=0, `timeout`=0.
  - `votes_cast`=0.
  - Debounce and timeout counters 0.
- All outputs are registered. `ready` = (state==ARMED), `busy` = (state!=IDLE), both registered with the state.
- Latency: with a clean one-hot press first seen in cycle N while ARMED, `vote_valid` rises in cycle N+`DEBOUNCE_CYCLES`.
- Handshake: `vote_valid` stays high until the cycle `vote_ack` is sampled high, and drops the following cycle.
  - `vote_ack` in the first SEND cycle completes the transfer, giving a minimum 1-cycle valid.
  - Ack-to-IDLE takes 2 cycles (SEND → DONE → IDLE).
- `reset` asserted in any state, including mid-SEND, returns to IDLE next edge. No partial vote is counted. `votes_cast` clears.

## Configuration
- `BALLOT_TIMEOUT_EN` defined:
  - A timeout counter runs only in ARMED and clears on entry to ARMED.
  - When it reaches `TIMEOUT_CYCLES` without a transition to SEND: go to IDLE and pulse `timeout` for one cycle. No vote is sent.
  - Debounce progress does not reset the timeout counter.
- `BALLOT_TIMEOUT_EN` not defined: no timeout counter, `timeout` is tied to 0, and ARMED waits indefinitely.

## Structure
- Shared package `evm_pkg`:
  - State enum `ballot_state_t` {IDLE, ARMED, SEND, DONE}.
  - Candidate code constants `CAND0`..`CAND3` = 2'b00..2'b11.
  - `VOTE_CNT_W`=16.
- One sub-module `btn_onehot_debounce`.
  - Inputs: `clk`, `reset`, `clr`, `btn[3:0]`.
  - Outputs: `stable` pulse and `code[1:0]`.
  - Contains the one-hot check, the candidate latch and the debounce counter.
  - `clr` is driven high whenever state != ARMED.
- The top level holds the FSM, the handshake, the timeout counter and `votes_cast`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=100.
- Clean vote: `arm` pulse, then `btn`=4'b0100 held 6 cycles, `vote_ack` 2 cycles after valid. Expect `vote_valid` on the 4th held cycle with `vote_sel`=2'b10, `votes_cast`=1, and IDLE 2 cycles after ack.
- Bounce and multi-press: `btn` sequence 0001,0000,0001,0011,0010×4 while ARMED. Expect no vote until the 4th consecutive 0010, then `vote_sel`=2'b01.
- Double vote blocked: after a completed vote, hold `btn`=1000 and pulse `arm` with no IDLE release. Expect no arming. After release plus `arm`, expect `ready`=1.
- Ack stall / reset mid-SEND: withhold `vote_ack` 10 cycles. Expect `vote_valid`=1 and `vote_sel` constant throughout. Assert `reset`: expect all outputs at reset values next cycle and `votes_cast`=0.
- Timeout (`BALLOT_TIMEOUT_EN` defined): arm, no press. Expect a `timeout` pulse 100 cycles after entering ARMED, IDLE, `votes_cast` unchanged. With the macro undefined, expect ARMED still held after 200 cycles.
- Saturation: preload 16'hFFFF via forced vote sequence. Expect one more acked vote leaves `votes_cast`=16'hFFFF.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared voting-machine types: ballot FSM states, candidate codes, vote
// counter width and small one-hot helpers.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    SEND  = 2'b10,
    DONE  = 2'b11
  } ballot_state_t;

  // Candidate codes match the counter block's select encoding.
  localparam logic [1:0] CAND0 = 2'b00;
  localparam logic [1:0] CAND1 = 2'b01;
  localparam logic [1:0] CAND2 = 2'b10;
  localparam logic [1:0] CAND3 = 2'b11;

  localparam int VOTE_CNT_W = 16;

  // True when exactly one button is pressed.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Button index to candidate code; only meaningful for one-hot inputs.
  function automatic logic [1:0] onehot_encode(input logic [3:0] v);
    case (v)
      4'b0010: return CAND1;
      4'b0100: return CAND2;
      4'b1000: return CAND3;
      default: return CAND0;
    endcase
  endfunction

endpackage

// File: rtl/btn_onehot_debounce.sv
// One-hot button debouncer: latches the candidate seen last cycle and counts
// consecutive identical one-hot samples. `stable` fires on the sample that
// brings the count to DEBOUNCE_CYCLES. Zero or multi-hot samples clear the
// count. `clr` holds everything cleared while the ballot is not armed.
module btn_onehot_debounce
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [3:0] btn,
  output logic       stable,
  output logic [1:0] code
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             onehot;
  logic             same;

  // Next debounce count and the stable-press detect.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_d  = '0;
    onehot = is_onehot(btn);
    same   = (btn == cand_q);
    if (onehot) begin
      if (!same)                cnt_d = CNT_W'(1);
      else if (cnt_q == CNT_DONE) cnt_d = cnt_q;
      else                      cnt_d = cnt_q + CNT_W'(1);
    end
    stable = !clr && onehot && (cnt_d == CNT_DONE);
    code   = onehot_encode(btn);
  end

  // Candidate latch and debounce counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q  <= '0;
      cand_q <= 4'b0000;
    end else begin
      cnt_q <= cnt_d;
      if (onehot && !same) cand_q <= btn;
    end
  end

endmodule

// File: rtl/ballot_unit.sv
// Ballot-side front end: arms one vote per `arm`, debounces the candidate
// buttons and offers a single 2-bit code to the counter over valid/ack.
// Optional feature: define BALLOT_TIMEOUT_EN to disarm an idle armed ballot
// after TIMEOUT_CYCLES with a one-cycle `timeout` pulse.
module ballot_unit
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [3:0]            btn,
  input  logic                  vote_ack,
  output logic                  vote_valid,
  output logic [1:0]            vote_sel,
  output logic                  ready,
  output logic                  busy,
  output logic [VOTE_CNT_W-1:0] votes_cast,
  output logic                  timeout
);

  ballot_state_t         state_q;
  ballot_state_t         state_d;
  logic                  stable;
  logic [1:0]            code;
  logic                  load_sel;
  logic                  count_vote;
  logic                  tmo_hit;
  logic [VOTE_CNT_W-1:0] vote_cnt_q;

  btn_onehot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ARMED),
    .btn   (btn),
    .stable(stable),
    .code  (code)
  );

`ifdef BALLOT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;

  // Expiry lands on the TIMEOUT_CYCLES-th edge spent in ARMED.
  assign tmo_hit = (state_q == ARMED) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  // Armed-time counter; held at zero outside ARMED so it restarts on entry.
  always_ff @(posedge clk) begin
    if (reset || state_q != ARMED) tmo_cnt_q <= '0;
    else                           tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

  // One-cycle timeout pulse; a press completing on the same edge wins.
  always_ff @(posedge clk) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= tmo_hit && !stable;
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state logic and the load/count strobes for the datapath.
  always_comb begin
    state_d    = state_q;
    load_sel   = 1'b0;
    count_vote = 1'b0;
    case (state_q)
      IDLE:  if (arm && btn == 4'b0000) state_d = ARMED;
      ARMED: begin
        if (stable) begin
          state_d  = SEND;
          load_sel = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (vote_ack) begin
          state_d    = DONE;
          count_vote = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with the registered status outputs, vote code and tally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vote_valid <= 1'b0;
      vote_sel   <= CAND0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      vote_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vote_valid <= (state_d == SEND);
      ready      <= (state_d == ARMED);
      busy       <= (state_d != IDLE);
      if (load_sel) vote_sel <= code;
      if (count_vote && vote_cnt_q != '1) vote_cnt_q <= vote_cnt_q + VOTE_CNT_W'(1);
    end
  end

  assign votes_cast = vote_cnt_q;

endmodule

// File: tb/tb_ballot_unit.sv
// Self-checking bench for ballot_unit (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100).
// Expected vote codes are queued when a press is driven and compared when
// the DUT raises vote_valid; the vote tally is tracked by a saturating model.
module tb_ballot_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm;
  logic [3:0]  btn;
  logic        vote_ack;
  logic        vote_valid;
  logic [1:0]  vote_sel;
  logic        ready;
  logic        busy;
  logic [15:0] votes_cast;
  logic        timeout;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q[$];
  logic [15:0] exp_votes = 16'h0000;

  ballot_unit #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .btn       (btn),
    .vote_ack  (vote_ack),
    .vote_valid(vote_valid),
    .vote_sel  (vote_sel),
    .ready     (ready),
    .busy      (busy),
    .votes_cast(votes_cast),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) check(tag, 32'(vote_sel), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n = 0;
    while (!vote_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(vote_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(vote_valid), 32'd0);
    check({tag, "_sel"},     32'(vote_sel),   32'd0);
    check({tag, "_ready"},   32'(ready),      32'd0);
    check({tag, "_busy"},    32'(busy),       32'd0);
    check({tag, "_timeout"}, 32'(timeout),    32'd0);
    check({tag, "_votes"},   32'(votes_cast), 32'd0);
  endtask

  task automatic model_count_vote();
    if (exp_votes != 16'hFFFF) exp_votes++;
  endtask

  // Full vote from IDLE (or ARMED): arm, press, ack in the first SEND cycle.
  task automatic do_vote(input logic [3:0] b, input logic [1:0] code, input string tag);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check({tag, "_ready"}, 32'(ready), 32'd1);
    btn = b;
    exp_q.push_back(code);
    wait_valid(20, tag);
    pop_check({tag, "_sel"});
    vote_ack = 1'b1;
    tick();
    vote_ack = 1'b0;
    btn      = 4'b0000;
    model_count_vote();
    check({tag, "_votes"},      32'(votes_cast), 32'(exp_votes));
    check({tag, "_valid_drop"}, 32'(vote_valid), 32'd0);
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [7];
    bit         seen;

    reset = 1'b1; arm = 1'b0; btn = 4'b0000; vote_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Clean vote: 0100 held, valid on the 4th sampled cycle, ack 2 cycles later.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("clean_ready", 32'(ready), 32'd1);
    check("clean_busy",  32'(busy),  32'd1);
    btn = 4'b0100;
    exp_q.push_back(2'b10);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("clean_deb_wait", 32'(vote_valid), 32'd0);
    end
    tick();
    check("clean_valid", 32'(vote_valid), 32'd1);
    check("clean_ready_low", 32'(ready), 32'd0);
    pop_check("clean_sel");
    tick();
    tick();
    check("clean_valid_hold", 32'(vote_valid), 32'd1);
    vote_ack = 1'b1;
    tick();
    vote_ack = 1'b0;
    model_count_vote();
    check("clean_valid_drop", 32'(vote_valid), 32'd0);
    check("clean_votes", 32'(votes_cast), 32'(exp_votes));
    check("clean_done_busy", 32'(busy), 32'd1);
    btn = 4'b0000;
    tick();
    check("clean_idle", 32'(busy), 32'd0);

    // Bounce and multi-press: no vote until the 4th consecutive 0010.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    seq = '{4'b0001, 4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0010, 4'b0010};
    exp_q.push_back(2'b01);
    for (int i = 0; i < 7; i++) begin
      btn = seq[i];
      tick();
      check("bounce_no_vote", 32'(vote_valid), 32'd0);
    end
    btn = 4'b0010;
    tick();
    check("bounce_valid", 32'(vote_valid), 32'd1);
    pop_check("bounce_sel");
    vote_ack = 1'b1;
    tick();
    vote_ack = 1'b0;
    btn = 4'b0000;
    model_count_vote();
    check("bounce_votes", 32'(votes_cast), 32'(exp_votes));
    tick();

    // Double vote blocked: a held button prevents arming until released.
    btn = 4'b1000;
    arm = 1'b1;
    tick();
    check("dbl_no_arm", 32'(ready), 32'd0);
    tick();
    check("dbl_no_arm_busy", 32'(busy), 32'd0);
    btn = 4'b0000;
    tick();
    arm = 1'b0;
    check("dbl_rearm_ready", 32'(ready), 32'd1);

    // Ack stall then reset mid-SEND.
    btn = 4'b0001;
    exp_q.push_back(2'b00);
    wait_valid(20, "stall");
    pop_check("stall_sel");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) btn = 4'b1000;
      if (i == 5) arm = 1'b1;
      tick();
      check("stall_valid", 32'(vote_valid), 32'd1);
      check("stall_sel_const", 32'(vote_sel), 32'd0);
    end
    arm = 1'b0;
    btn = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_votes = 16'h0000;
    check_reset_outputs("midsend_rst");

`ifdef BALLOT_TIMEOUT_EN
    // Timeout: armed with no press expires 100 cycles after entering ARMED.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    check("tmo_early", 32'(seen), 32'd0);
    check("tmo_still_armed", 32'(ready), 32'd1);
    tick();
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_votes", 32'(votes_cast), 32'(exp_votes));
    tick();
    check("tmo_pulse_end", 32'(timeout), 32'd0);
`else
    // No timeout: an armed ballot waits indefinitely.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    check("notmo_armed", 32'(ready), 32'd1);
    check("notmo_busy", 32'(busy), 32'd1);
    check("notmo_no_pulse", 32'(seen), 32'd0);
`endif

    // Saturation: preload the tally near full, then vote twice.
    force dut.vote_cnt_q = 16'hFFFE;
    #1;
    release dut.vote_cnt_q;
    exp_votes = 16'hFFFE;
    do_vote(4'b1000, 2'b11, "sat1");
    check("sat1_full", 32'(votes_cast), 32'h0000FFFF);
    do_vote(4'b0100, 2'b10, "sat2");
    check("sat2_hold", 32'(votes_cast), 32'h0000FFFF);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
